// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Holds the data memory, builds store byte enables, aligns/extends loads,
// classifies address exceptions for CP0 and registers results into MW_*.
// Optional macro DEV_BRIDGE_EN: when defined, the 0x20-byte device window at
// DEV_BASE is decoded and routed to the bridge (PrAddr/PrWD/PrWE/PrRD);
// when undefined, device addresses are simply out of range.
module mem_stage #(
  parameter int unsigned DM_WORDS = 3072,
  parameter logic [31:0] DEV_BASE = 32'h7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_instruc,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_AluRe,
  input  logic [31:0] M_WTDM,
  input  logic [4:0]  M_WRA,
  input  logic [4:0]  M_ExcIn,
  input  logic        M_BDIn,
  input  logic [31:0] W_WRD,
  input  logic        PassSrcM,
  input  logic        IntReq,
  input  logic [31:0] PrRD,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWE,
  output logic [31:0] M_Pass,
  output logic [4:0]  M_ExcCode,
  output logic [31:0] MW_instruc,
  output logic [31:0] MW_AluRe,
  output logic [31:0] MW_DMRD,
  output logic [31:0] MW_PC,
  output logic [4:0]  MW_WRA,
  output logic        MW_BD
);

  localparam int unsigned AW       = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  logic [31:0] r_dm [DM_WORDS];

  logic [31:0] r_mw_instruc, r_mw_alure, r_mw_dmrd, r_mw_pc;
  logic [4:0]  r_mw_wra;
  logic        r_mw_bd;

  logic [5:0]    w_op;
  logic          w_ld, w_st, w_word, w_half, w_byte;
  logic [31:0]   w_sd;
  logic [AW-1:0] w_idx;
  logic          w_in_dm, w_in_dev, w_cnt, w_misal, w_bad;
  logic [4:0]    w_exc;
  logic          w_commit, w_dm_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_rword, w_ldval;
  logic [15:0]   w_hsel;
  logic [7:0]    w_bsel;

  assign w_op   = M_instruc[31:26];
  assign w_ld   = (w_op == OP_LW) || (w_op == OP_LH) || (w_op == OP_LHU) ||
                  (w_op == OP_LB) || (w_op == OP_LBU);
  assign w_st   = (w_op == OP_SW) || (w_op == OP_SH) || (w_op == OP_SB);
  assign w_word = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_half = (w_op == OP_LH) || (w_op == OP_LHU) || (w_op == OP_SH);
  assign w_byte = (w_op == OP_LB) || (w_op == OP_LBU) || (w_op == OP_SB);

  assign w_sd    = PassSrcM ? W_WRD : M_WTDM;
  assign w_idx   = M_AluRe[AW+1:2];
  assign w_in_dm = (M_AluRe < DM_BYTES);

`ifdef DEV_BRIDGE_EN
  logic [31:0] w_off;
  assign w_off    = M_AluRe - DEV_BASE;
  // Window is 0x00-0x1B with the 0x0C-0x0F hole between the two timers.
  assign w_in_dev = (M_AluRe >= DEV_BASE) && (w_off <= 32'h1B) && (w_off[4:2] != 3'b011);
  // COUNT register of either timer is read-only.
  assign w_cnt    = w_in_dev && (w_off[3:2] == 2'b10);
  assign PrAddr   = M_AluRe;
  assign PrWD     = w_sd;
  assign PrWE     = w_commit && w_in_dev;
  assign w_rword  = w_in_dev ? PrRD : (w_in_dm ? r_dm[w_idx] : 32'h0);
`else
  logic w_unused;
  assign w_unused = ^{PrRD, DEV_BASE};
  assign w_in_dev = 1'b0;
  assign w_cnt    = 1'b0;
  assign PrAddr   = 32'h0;
  assign PrWD     = 32'h0;
  assign PrWE     = 1'b0;
  assign w_rword  = w_in_dm ? r_dm[w_idx] : 32'h0;
`endif

  assign w_misal = (w_word && (M_AluRe[1:0] != 2'b00)) || (w_half && M_AluRe[0]);
  assign w_bad   = w_misal || !(w_in_dm || w_in_dev) || (w_in_dev && !w_word);

  // Exception classification, highest priority first.
  always_comb begin
    w_exc = EXC_NONE;
    if ((w_ld || w_st) && (M_ExcIn == EXC_OV)) begin
      w_exc = w_ld ? EXC_ADEL : EXC_ADES;
    end else if (M_ExcIn != EXC_NONE) begin
      w_exc = M_ExcIn;
    end else if (w_ld && w_bad) begin
      w_exc = EXC_ADEL;
    end else if (w_st && (w_bad || w_cnt)) begin
      w_exc = EXC_ADES;
    end
  end

  assign M_ExcCode = w_exc;
  assign M_Pass    = M_AluRe;
  assign w_commit  = w_st && (w_exc == EXC_NONE) && !IntReq && !reset;
  assign w_dm_we   = w_commit && w_in_dm;

  // Store byte enables and lane-replicated write data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_sd;
    if (w_half) begin
      w_be    = M_AluRe[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{w_sd[15:0]}};
    end else if (w_byte) begin
      w_be    = 4'b0001 << M_AluRe[1:0];
      w_wdata = {4{w_sd[7:0]}};
    end
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    w_hsel  = M_AluRe[1] ? w_rword[31:16] : w_rword[15:0];
    w_bsel  = w_rword[{M_AluRe[1:0], 3'b000} +: 8];
    w_ldval = w_rword;
    case (w_op)
      OP_LH:   w_ldval = {{16{w_hsel[15]}}, w_hsel};
      OP_LHU:  w_ldval = {16'h0, w_hsel};
      OP_LB:   w_ldval = {{24{w_bsel[7]}}, w_bsel};
      OP_LBU:  w_ldval = {24'h0, w_bsel};
      default: w_ldval = w_rword;
    endcase
  end

  // Data memory: cleared on reset, byte-granular writes on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) r_dm[i] <= 32'h0;
    end else if (w_dm_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_dm[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // M/W pipeline registers; a flush clears the payload but keeps PC/BD for CP0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mw_instruc <= 32'h0;
      r_mw_alure   <= 32'h0;
      r_mw_dmrd    <= 32'h0;
      r_mw_pc      <= 32'h0;
      r_mw_wra     <= 5'h0;
      r_mw_bd      <= 1'b0;
    end else if (IntReq) begin
      r_mw_instruc <= 32'h0;
      r_mw_alure   <= 32'h0;
      r_mw_dmrd    <= 32'h0;
      r_mw_wra     <= 5'h0;
    end else begin
      r_mw_instruc <= M_instruc;
      r_mw_alure   <= M_AluRe;
      r_mw_dmrd    <= w_ldval;
      r_mw_pc      <= M_PC;
      r_mw_wra     <= M_WRA;
      r_mw_bd      <= M_BDIn;
    end
  end

  assign MW_instruc = r_mw_instruc;
  assign MW_AluRe   = r_mw_alure;
  assign MW_DMRD    = r_mw_dmrd;
  assign MW_PC      = r_mw_pc;
  assign MW_WRA     = r_mw_wra;
  assign MW_BD      = r_mw_bd;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access (M) pipeline stage of the five-stage MIPS core. It sits directly downstream of the execute stage and consumes its EM_* pipeline registers. It holds the data memory, builds byte enables for stores, aligns and extends loads, and routes device-window accesses to the bridge. It classifies address exceptions for CP0 and registers results into the MW_* pipeline registers feeding write-back.

## Interface
Parameters:
- DM_WORDS, 3072: data-memory depth in 32-bit words; valid DM byte range is 0 .. 4*DM_WORDS-1.
- DEV_BASE, 32'h7F00: first byte of the device window; the window spans 0x20 bytes (timer0 at 0x00–0x0B, timer1 at 0x10–0x1B).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- M_instruc  in  32  instruction from the execute stage.
- M_PC  in  32  instruction PC.
- M_AluRe  in  32  ALU result; the effective address for memory ops.
- M_WTDM  in  32  store data from the execute stage.
- M_WRA  in  5  destination register.
- M_ExcIn  in  5  exception code carried from earlier stages.
- M_BDIn  in  1  branch-delay flag.
- W_WRD  in  32  write-back data, used for store-data forwarding.
- PassSrcM  in  1  1 = use W_WRD as store data; 0 = use M_WTDM.
- IntReq  in  1  CP0 interrupt/exception flush.
- PrRD  in  32  bridge read data.
- PrAddr  out  32  bridge address.
- PrWD  out  32  bridge write data.
- PrWE  out  1  bridge write strobe.
- M_Pass  out  32  forwarding value to the execute stage; equals M_AluRe.
- M_ExcCode  out  5  combinational exception code of the current M instruction, to CP0.
- MW_instruc, MW_AluRe, MW_DMRD, MW_PC  out  32 each  registered to write-back.
- MW_WRA  out  5  registered destination register.
- MW_BD  out  1  registered branch-delay flag.

## Operation
- Opcode decode:
  - Loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - Stores: sw 0x2B, sh 0x29, sb 0x28.
  - Every other opcode does no memory access.
- Address A = M_AluRe. Store data SD = PassSrcM ? W_WRD : M_WTDM.
- DM region: A < 4*DM_WORDS. Device region: DEV_BASE <= A <= DEV_BASE+0x1B, excluding offsets 0x0C–0x0F.
- Store byte enables:
  - sw: 4'b1111.
  - sh: 4'b0011 << (2*A[1]); data is {2{SD[15:0]}}.
  - sb: 4'b0001 << A[1:0]; data is {4{SD[7:0]}}.
- Load extraction from word W:
  - lw: W.
  - lh/lhu: halfword at A[1], sign- or zero-extended.
  - lb/lbu: byte at A[1:0], sign- or zero-extended.
- Exception codes: 0 none, 4 AdEL, 5 AdES, 12 Ov.
- Exception priority, first match wins:
  1. M_ExcIn equals 12 on a load → AdEL; on a store → AdES.
  2. Any other non-zero M_ExcIn is passed through unchanged.
  3. Load with misalignment (lw A[1:0]≠0; lh/lhu A[0]≠0), address outside both regions, or non-word access to the device region → AdEL.
  4. Store with the same conditions → AdES. A store to timer offset 0x08 or 0x18 (the COUNT register) is also AdES.
  5. Otherwise 0.
- A write commits only when all of these hold: store, M_ExcCode==0, IntReq==0, reset==0.
  - DM address: the enabled bytes of word A[31:2] are written.
  - Device address: PrWE=1.
- PrAddr = A and PrWD = SD at all times. PrWE is asserted only under the commit condition.

## Timing
- DM reads are combinational. The extracted load value is captured into MW_DMRD at the next edge, so load data reaches write-back one cycle after M.
- DM writes and PrWE take effect at the rising edge that ends the M cycle.
- A load following a store to the same word in the next cycle reads the updated data.
- On reset:
  - All MW_* outputs go to 0.
  - All DM words are cleared to 0.
  - PrWE is 0 in that cycle.
- On IntReq (when reset is not asserted):
  - MW_instruc, MW_AluRe, MW_DMRD and MW_WRA go to 0.
  - MW_PC and MW_BD hold their values.
  - No memory or device write occurs.
- Otherwise all MW_* registers load the current M values each cycle; there is no stall input, and the stage never holds.
- M_ExcCode is combinational and valid within the same cycle for CP0.

## Configuration
- DEV_BRIDGE_EN defined: the device window is decoded as described above, PrWE is driven, and device loads take PrRD.
- DEV_BRIDGE_EN undefined:
  - The device region does not exist; device addresses raise AdEL or AdES as out-of-range.
  - PrAddr, PrWD and PrWE are tied to 0.
  - PrRD is ignored.

## Test plan
- sw 0x12345678 to A=0x10, then lw A=0x10 the next cycle → MW_DMRD = 0x12345678, M_ExcCode = 0.
- sb 0xAB to A=0x13, then lb A=0x13 → MW_DMRD = 0xFFFFFFAB; lbu on the same address → 0x000000AB; word 0x10 reads 0xAB345678.
- lh A=0x11 → M_ExcCode = 4 and MW_DMRD is ignored; sw A=0x3000 with DM_WORDS=3072 → M_ExcCode = 5 and memory is unchanged.
- sw to 0x7F04 with DEV_BRIDGE_EN → PrWE=1, PrAddr=0x7F04; sw to 0x7F08 → M_ExcCode = 5, PrWE=0; without the macro, sw to 0x7F04 → M_ExcCode = 5.
- sw with IntReq=1 → no write, MW_instruc = 0; a later lw on the same address returns the old value.
- sw with PassSrcM=1 and W_WRD = 0xCAFEF00D → memory holds 0xCAFEF00D, not M_WTDM; M_ExcIn=12 on a load → M_ExcCode = 4.
